// File: rtl/swi_conditioner_if.sv
// Switch-conditioner bus: raw switch levels and event clears in,
// debounced levels, edge pulses and sticky event flags out.
interface swi_conditioner_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] swi_raw;
    logic [NBITS-1:0] clr_evt;
    logic [NBITS-1:0] swi_stable;
    logic [NBITS-1:0] swi_rise;
    logic [NBITS-1:0] swi_fall;
    logic [NBITS-1:0] evt_latch;
    logic             any_change;

    modport master (
        output swi_raw, clr_evt,
        input  swi_stable, swi_rise, swi_fall, evt_latch, any_change
    );

    modport slave (
        input  swi_raw, clr_evt,
        output swi_stable, swi_rise, swi_fall, evt_latch, any_change
    );
endinterface

// File: rtl/swi_conditioner.sv
// Per-bit switch conditioning: 2-flop synchronizer, stability-counter debounce,
// registered rise/fall pulses and sticky rise-event flags.
module swi_conditioner #(
    parameter int NBITS           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             reset_n,
    swi_conditioner_if.slave bus
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NBITS-1:0] stable;
    logic [NBITS-1:0] rise;
    logic [NBITS-1:0] fall;
    logic [NBITS-1:0] evt;

    genvar i;
    generate
        for (i = 0; i < NBITS; i++) begin : g_bit
            logic          s1, s2, st, r, f, e;
            logic [CW-1:0] cnt;
            logic          mism, accept;

            assign mism   = s2 ^ st;
            assign accept = mism && (cnt == CNT_LAST);

            always_ff @(posedge clk_2 or negedge reset_n) begin
                if (!reset_n) begin
                    s1  <= 1'b0;
                    s2  <= 1'b0;
                    st  <= 1'b0;
                    r   <= 1'b0;
                    f   <= 1'b0;
                    e   <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= bus.swi_raw[i];
                    s2 <= s1;
                    // Pulses are registered alongside the stable level so they line up.
                    r  <= accept & s2;
                    f  <= accept & ~s2;
                    if (!mism || accept) cnt <= '0;
                    else                 cnt <= cnt + 1'b1;
                    if (accept) st <= s2;
                    // The sticky flag follows the visible rise pulse; set beats clear.
                    if (r)                   e <= 1'b1;
                    else if (bus.clr_evt[i]) e <= 1'b0;
                end
            end

            assign stable[i] = st;
            assign rise[i]   = r;
            assign fall[i]   = f;
            assign evt[i]    = e;
        end
    endgenerate

    assign bus.swi_stable = stable;
    assign bus.swi_rise   = rise;
    assign bus.swi_fall   = fall;
    assign bus.evt_latch  = evt;
    assign bus.any_change = |(rise | fall);
endmodule

// File: tb/tb_swi_conditioner.sv
// Self-checking bench for swi_conditioner: directed scenarios plus a randomized
// run checked cycle by cycle against a run-length reference model.
module tb_swi_conditioner;
    localparam int NB = 8;
    localparam int D  = 4;

    logic clk_2;
    logic reset_n;
    int   comps;
    int   errs;

    swi_conditioner_if #(.NBITS(NB)) bus ();

    swi_conditioner #(.NBITS(NB), .DEBOUNCE_CYCLES(D)) dut (
        .clk_2  (clk_2),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk_2 = 1'b0;
        forever #5 clk_2 = ~clk_2;
    end

    // Reference model: a bit is accepted once its synchronized value has
    // disagreed with the stable value for D consecutive edges.
    logic [NB-1:0] m_s1, m_s2, m_st, m_r, m_f, m_e;
    int            run [NB];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_st = '0; m_r = '0; m_f = '0; m_e = '0;
        for (int i = 0; i < NB; i++) run[i] = 0;
    endtask

    task automatic tick();
        logic [NB-1:0] raw, clr, ne;
        raw = bus.swi_raw;
        clr = bus.clr_evt;
        @(posedge clk_2);
        if (reset_n) begin
            ne = m_e;
            for (int i = 0; i < NB; i++) begin
                if (m_r[i])      ne[i] = 1'b1;
                else if (clr[i]) ne[i] = 1'b0;
            end
            m_r = '0;
            m_f = '0;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_st[i]) begin
                    run[i]++;
                    if (run[i] == D) begin
                        m_st[i] = m_s2[i];
                        run[i]  = 0;
                        if (m_s2[i]) m_r[i] = 1'b1;
                        else         m_f[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_e  = ne;
            m_s2 = m_s1;
            m_s1 = raw;
        end
        #1;
    endtask

    task automatic settle(input logic [NB-1:0] raw);
        bus.swi_raw = raw;
        bus.clr_evt = '1;
        repeat (10) tick();
        bus.clr_evt = '0;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.swi_raw = '1;
        bus.clr_evt = '0;
        model_reset();
        repeat (3) tick();
        comps++;
        if ({bus.swi_stable, bus.swi_rise, bus.swi_fall, bus.evt_latch, bus.any_change} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got stable=%h rise=%h fall=%h evt=%h any=%b, want all 0",
                     bus.swi_stable, bus.swi_rise, bus.swi_fall, bus.evt_latch, bus.any_change);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) begin
                comps++;
                if (bus.swi_stable !== 8'h00) begin
                    errs++;
                    $display("FAIL reset_early_stable edge %0d: got %h want 00", e, bus.swi_stable);
                end
            end else if (e == 6) begin
                comps++;
                if (bus.swi_stable !== 8'hFF || bus.swi_rise !== 8'hFF || bus.any_change !== 1'b1) begin
                    errs++;
                    $display("FAIL reset_rise edge 6: got stable=%h rise=%h any=%b want FF FF 1",
                             bus.swi_stable, bus.swi_rise, bus.any_change);
                end
            end else begin
                comps++;
                if (bus.evt_latch !== 8'hFF || bus.swi_rise !== 8'h00 || bus.any_change !== 1'b0) begin
                    errs++;
                    $display("FAIL reset_evt edge 7: got evt=%h rise=%h any=%b want FF 00 0",
                             bus.evt_latch, bus.swi_rise, bus.any_change);
                end
            end
        end
    endtask

    task automatic test_clean_press();
        int first, rises, falls;
        first = 0; rises = 0; falls = 0;
        bus.swi_raw[3] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (bus.swi_stable[3] && first == 0) first = e;
            rises += int'(bus.swi_rise[3]);
            if (bus.swi_fall !== '0) falls++;
        end
        comps++;
        if (first != 6 || rises != 1 || falls != 0) begin
            errs++;
            $display("FAIL clean_press: got edge=%0d rises=%0d falls=%0d want 6 1 0", first, rises, falls);
        end
    endtask

    task automatic test_bounce();
        int first, rises;
        first = 0; rises = 0;
        for (int e = 1; e <= 20; e++) begin
            // Level seen after edge e-1: 1,1,0,0,1,1,0,0 then held high from edge 8.
            bus.swi_raw[5] = (e > 8) ? 1'b1 : ~((e - 1) >> 1 & 1);
            tick();
            if (bus.swi_stable[5] && first == 0) first = e;
            rises += int'(bus.swi_rise[5]);
        end
        comps++;
        if (first != 14 || rises != 1) begin
            errs++;
            $display("FAIL bounce: got edge=%0d rises=%0d want 14 1", first, rises);
        end
    endtask

    task automatic test_glitch();
        int pulses, hi;
        pulses = 0; hi = 0;
        for (int e = 1; e <= 12; e++) begin
            bus.swi_raw[0] = (e <= 3);
            tick();
            if (bus.swi_rise[0] || bus.swi_fall[0]) pulses++;
            if (bus.swi_stable[0]) hi++;
        end
        comps++;
        if (pulses != 0 || hi != 0) begin
            errs++;
            $display("FAIL glitch: got pulses=%0d stable_hi=%0d want 0 0", pulses, hi);
        end
    endtask

    task automatic test_release();
        int  first, falls;
        logic evt0, evt_changed;
        bus.swi_raw[2] = 1'b1;
        repeat (10) tick();
        evt0 = bus.evt_latch[2];
        comps++;
        if (evt0 !== 1'b1 || bus.swi_stable[2] !== 1'b1) begin
            errs++;
            $display("FAIL release_setup: got evt=%b stable=%b want 1 1", evt0, bus.swi_stable[2]);
        end
        first = 0; falls = 0; evt_changed = 1'b0;
        bus.swi_raw[2] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (bus.swi_fall[2] && first == 0) first = e;
            falls += int'(bus.swi_fall[2]);
            if (bus.evt_latch[2] !== evt0) evt_changed = 1'b1;
        end
        comps++;
        if (first != 6 || falls != 1 || evt_changed) begin
            errs++;
            $display("FAIL release: got edge=%0d falls=%0d evt_changed=%b want 6 1 0", first, falls, evt_changed);
        end
    endtask

    task automatic test_latch_priority();
        int found;
        bus.clr_evt = '1;
        tick();
        bus.clr_evt = '0;
        found = 0;
        bus.swi_raw[1] = 1'b1;
        for (int e = 1; e <= 10 && found == 0; e++) begin
            tick();
            if (bus.swi_rise[1]) found = e;
        end
        comps++;
        if (found != 6 || bus.evt_latch[1] !== 1'b0) begin
            errs++;
            $display("FAIL latch_rise: got edge=%0d evt=%b want 6 0", found, bus.evt_latch[1]);
        end
        bus.clr_evt[1] = 1'b1;
        tick();
        comps++;
        if (bus.evt_latch[1] !== 1'b1) begin
            errs++;
            $display("FAIL latch_set_wins: got %b want 1", bus.evt_latch[1]);
        end
        tick();
        comps++;
        if (bus.evt_latch[1] !== 1'b0) begin
            errs++;
            $display("FAIL latch_clear: got %b want 0", bus.evt_latch[1]);
        end
        bus.clr_evt = '0;
    endtask

    task automatic test_async_reset();
        logic [NB-1:0] raw;
        int            first;
        raw = bus.swi_raw ^ 8'h40;
        bus.swi_raw = raw;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        comps++;
        if ({bus.swi_stable, bus.swi_rise, bus.swi_fall, bus.evt_latch, bus.any_change} !== '0) begin
            errs++;
            $display("FAIL async_reset: got stable=%h evt=%h, want 00 00", bus.swi_stable, bus.evt_latch);
        end
        model_reset();
        tick();
        reset_n = 1'b1;
        first = 0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (bus.swi_stable !== 8'h00 && first == 0) first = e;
        end
        comps++;
        if (first != 6 || bus.swi_stable !== raw) begin
            errs++;
            $display("FAIL reset_recount: got edge=%0d stable=%h want 6 %h", first, bus.swi_stable, raw);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] flip;
        for (int c = 0; c < 400; c++) begin
            flip = '0;
            for (int i = 0; i < NB; i++) flip[i] = ($urandom_range(0, 5) == 0);
            bus.swi_raw = bus.swi_raw ^ flip;
            bus.clr_evt = NB'($urandom & $urandom);
            tick();
            comps++;
            if (bus.swi_stable !== m_st || bus.swi_rise !== m_r || bus.swi_fall !== m_f ||
                bus.evt_latch !== m_e || bus.any_change !== |(m_r | m_f)) begin
                errs++;
                $display("FAIL random cyc %0d: got st=%h r=%h f=%h e=%h a=%b want st=%h r=%h f=%h e=%h a=%b",
                         c, bus.swi_stable, bus.swi_rise, bus.swi_fall, bus.evt_latch, bus.any_change,
                         m_st, m_r, m_f, m_e, |(m_r | m_f));
            end
        end
        bus.clr_evt = '0;
    endtask

    initial begin
        comps = 0;
        errs  = 0;
        test_reset();
        settle('0);
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release();
        test_latch_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
        $finish;
    end
endmodule
